// File: rtl/invmat_feeder.sv
// Row-major element stream to flat N x N matrix bus for the matrix inverter.
// Frames are checked for length, and the number of matrices in flight is capped.
module invmat_feeder #(
  parameter int MAT_SIZE   = 5,
  parameter int MAT_DWIDTH = 46,
  parameter int MAX_OUT    = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [MAT_DWIDTH-1:0]                    s_data,
  input  logic                                     s_valid,
  input  logic                                     s_last,
  output logic                                     s_ready,
  input  logic                                     inv_ready,
  input  logic                                     inv_out_vld,
  output logic [MAT_DWIDTH*MAT_SIZE*MAT_SIZE-1:0]  mat_in,
  output logic                                     mat_vld,
  output logic [$clog2(MAX_OUT+1)-1:0]             outstanding,
  output logic                                     frame_err,
  output logic [15:0]                              mat_count
);

  localparam int NN   = MAT_SIZE * MAT_SIZE;
  localparam int IDXW = $clog2(NN);
  localparam int OW   = $clog2(MAX_OUT + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);
  localparam logic [OW-1:0]   CAP      = OW'(MAX_OUT);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    HOLD       = 2'd1,
    HOLD_DRAIN = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IDXW-1:0]             idx, idx_nxt;
  logic [MAT_DWIDTH-1:0]       asm_mem [NN];
  logic [NN*MAT_DWIDTH-1:0]    asm_flat;
  logic                        accept;
  logic                        can_issue;
  logic                        issue;
  logic                        store;
  logic                        err;
  logic                        done;

  // Ready depends on state only; forced low while reset is held.
  assign s_ready   = ~reset & ((state == FILL) | (state == DRAIN));
  assign accept    = s_valid & s_ready;
  assign can_issue = inv_ready & (outstanding < CAP);
  assign done      = inv_out_vld & (outstanding != '0);

  for (genvar k = 0; k < NN; k++) begin : g_flat
    assign asm_flat[k*MAT_DWIDTH +: MAT_DWIDTH] = asm_mem[k];
  end

  // NOTE: every signal driven here gets a default first so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    issue     = 1'b0;
    store     = 1'b0;
    err       = 1'b0;
    unique case (state)
      FILL: begin
        if (accept) begin
          store = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            err       = ~s_last;
            state_nxt = s_last ? HOLD : HOLD_DRAIN;
          end else if (s_last) begin
            idx_nxt = '0;
            err     = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      HOLD, HOLD_DRAIN: begin
        if (can_issue) begin
          issue     = 1'b1;
          state_nxt = (state == HOLD) ? FILL : DRAIN;
        end
      end
      DRAIN: begin
        if (accept && s_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      idx         <= '0;
      mat_in      <= '0;
      mat_vld     <= 1'b0;
      frame_err   <= 1'b0;
      mat_count   <= '0;
      outstanding <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      mat_vld   <= issue;
      frame_err <= err;
      if (issue) begin
        mat_in    <= asm_flat;
        mat_count <= mat_count + 16'd1;
      end
      unique case ({issue, done})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // NOTE: the assembly array is not reset; idx restarts at 0, so stale entries are always overwritten before issue.
  always_ff @(posedge clk) begin
    if (store) asm_mem[idx] <= s_data;
  end

endmodule

// File: tb/tb_invmat_feeder.sv
// Self-checking bench for invmat_feeder: queue-based frame model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_invmat_feeder;

  localparam int N   = 5;
  localparam int W   = 46;
  localparam int MO  = 2;
  localparam int NN  = N * N;
  localparam int OW  = $clog2(MO + 1);

  logic                clk;
  logic                reset;
  logic [W-1:0]        s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic                inv_ready;
  logic                inv_out_vld;
  logic [W*NN-1:0]     mat_in;
  logic                mat_vld;
  logic [OW-1:0]       outstanding;
  logic                frame_err;
  logic [15:0]         mat_count;

  invmat_feeder #(.MAT_SIZE(N), .MAT_DWIDTH(W), .MAX_OUT(MO)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .inv_ready  (inv_ready),
    .inv_out_vld(inv_out_vld),
    .mat_in     (mat_in),
    .mat_vld    (mat_vld),
    .outstanding(outstanding),
    .frame_err  (frame_err),
    .mat_count  (mat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int vld_seen = 0;
  int err_seen = 0;
  bit chk_en   = 1'b0;
  bit rand_ctl = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_FILL, M_HOLD, M_HOLD_DROP, M_DRAIN} mmode_t;
  mmode_t       m_mode = M_FILL;
  logic [W-1:0] cur[$];
  logic [W-1:0] pend[NN];
  logic [W-1:0] exp_mat[NN];
  bit           exp_vld = 1'b0;
  bit           exp_err = 1'b0;
  int           m_out = 0;
  logic [15:0]  m_count = '0;

  task automatic model_step();
    bit acc, iss, dn;
    if (reset) begin
      m_mode = M_FILL; cur.delete(); exp_vld = 0; exp_err = 0; m_out = 0; m_count = '0;
      foreach (exp_mat[k]) exp_mat[k] = '0;
      return;
    end
    acc = s_valid && (m_mode == M_FILL || m_mode == M_DRAIN);
    iss = (m_mode == M_HOLD || m_mode == M_HOLD_DROP) && inv_ready && (m_out < MO);
    dn  = inv_out_vld && (m_out > 0);
    exp_vld = iss;
    exp_err = 0;
    case (m_mode)
      M_FILL: if (acc) begin
        cur.push_back(s_data);
        if (cur.size() == NN) begin
          for (int k = 0; k < NN; k++) pend[k] = cur[k];
          cur.delete();
          exp_err = !s_last;
          m_mode  = s_last ? M_HOLD : M_HOLD_DROP;
        end else if (s_last) begin
          cur.delete();
          exp_err = 1;
        end
      end
      M_HOLD, M_HOLD_DROP: if (iss) begin
        exp_mat = pend;
        m_count = m_count + 16'd1;
        m_mode  = (m_mode == M_HOLD) ? M_FILL : M_DRAIN;
      end
      M_DRAIN: if (acc && s_last) m_mode = M_FILL;
      default: m_mode = M_FILL;
    endcase
    m_out = m_out + int'(iss) - int'(dn);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (mat_vld === 1'b1) vld_seen++;
    if (frame_err === 1'b1) err_seen++;
    if (chk_en) begin
      int bad;
      bit rdy;
      rdy = !reset && (m_mode == M_FILL || m_mode == M_DRAIN);
      check("s_ready", 64'(s_ready), 64'(rdy));
      check("mat_vld", 64'(mat_vld), reset ? 64'd0 : 64'(exp_vld));
      check("frame_err", 64'(frame_err), reset ? 64'd0 : 64'(exp_err));
      check("outstanding", 64'(outstanding), reset ? 64'd0 : 64'(m_out));
      check("mat_count", 64'(mat_count), reset ? 64'd0 : 64'(m_count));
      bad = -1;
      for (int k = 0; k < NN; k++) begin
        logic [W-1:0] e;
        e = reset ? '0 : exp_mat[k];
        if (bad < 0 && mat_in[k*W +: W] !== e) bad = k;
      end
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL mat_in slice %0d: got %0h expected %0h at %0t", bad,
                 mat_in[bad*W +: W], reset ? '0 : exp_mat[bad], $time);
      end
    end
  end

  // Randomized inverter handshake for the random phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ctl) begin
      inv_ready   = ($urandom_range(0, 2) != 0);
      inv_out_vld = (m_out > 0) && ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_elem(input logic [W-1:0] d, input bit last);
    int budget;
    budget = 0;
    s_data = d; s_last = last; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      budget++;
      if (budget > 300) begin
        check("s_ready_timeout", 64'(s_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_elem(W'({$urandom, $urandom}), i == len - 1);
    end
  endtask

  task automatic complete_one();
    inv_out_vld = 1'b1;
    idle(1);
    inv_out_vld = 1'b0;
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int v0, e0;
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    inv_ready = 1'b0; inv_out_vld = 1'b0;
    idle(3);
    chk_en = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_mat_vld", 64'(mat_vld), 64'd0);
    check("rst_count", 64'(mat_count), 64'd0);
    check("rst_out", 64'(outstanding), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // Single matrix, values 1..25 in <31.14>
    inv_ready = 1'b1;
    for (int i = 0; i < NN; i++) send_elem(W'(64'h4000 * (i + 1)), i == NN - 1);
    @(negedge clk);
    check("single_vld_t1", 64'(mat_vld), 64'd0);
    @(negedge clk);
    check("single_vld_t2", 64'(mat_vld), 64'd1);
    for (int k = 0; k < NN; k++) check("single_slice", 64'(mat_in[k*W +: W]), 64'h4000 * (k + 1));
    check("single_count", 64'(mat_count), 64'd1);
    check("single_out", 64'(outstanding), 64'd1);
    @(posedge clk); #1;
    complete_one();

    // Back-pressure
    inv_ready = 1'b0;
    v0 = vld_seen;
    send_frame(NN, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("bp_s_ready", 64'(s_ready), 64'd0);
      check("bp_mat_vld", 64'(mat_vld), 64'd0);
    end
    @(posedge clk); #1;
    inv_ready = 1'b1;
    @(negedge clk);
    check("bp_vld_early", 64'(mat_vld), 64'd0);
    @(negedge clk);
    check("bp_vld_rise", 64'(mat_vld), 64'd1);
    check("bp_issues", 64'(vld_seen - v0), 64'd1);
    @(posedge clk); #1;
    complete_one();

    // Outstanding cap
    v0 = vld_seen;
    repeat (3) send_frame(NN, 1'b0);
    idle(5);
    check("cap_out", 64'(outstanding), 64'd2);
    check("cap_s_ready", 64'(s_ready), 64'd0);
    check("cap_issues", 64'(vld_seen - v0), 64'd2);
    complete_one();
    idle(2);
    check("cap_out_after", 64'(outstanding), 64'd2);
    check("cap_issues_after", 64'(vld_seen - v0), 64'd3);
    send_frame(NN, 1'b0);
    idle(2);
    inv_out_vld = 1'b1;
    idle(1);
    idle(1);
    inv_out_vld = 1'b0;
    @(negedge clk);
    check("coinc_vld", 64'(mat_vld), 64'd1);
    check("coinc_out", 64'(outstanding), 64'd1);
    @(posedge clk); #1;
    complete_one();
    complete_one();
    @(negedge clk);
    check("ovld_at_zero", 64'(outstanding), 64'd0);
    @(posedge clk); #1;

    // Early s_last
    v0 = vld_seen; e0 = err_seen;
    send_frame(10, 1'b0);
    @(negedge clk);
    check("early_err", 64'(frame_err), 64'd1);
    @(posedge clk); #1;
    idle(3);
    check("early_err_cnt", 64'(err_seen - e0), 64'd1);
    check("early_no_vld", 64'(vld_seen - v0), 64'd0);
    send_frame(NN, 1'b0);
    idle(3);
    check("early_next_issue", 64'(vld_seen - v0), 64'd1);
    complete_one();

    // Late s_last: 28 elements
    v0 = vld_seen; e0 = err_seen;
    send_frame(28, 1'b0);
    idle(3);
    check("late_err_cnt", 64'(err_seen - e0), 64'd1);
    check("late_issue", 64'(vld_seen - v0), 64'd1);
    complete_one();
    send_frame(NN, 1'b0);
    idle(3);
    check("late_next_issue", 64'(vld_seen - v0), 64'd2);
    complete_one();

    // Reset mid-fill
    send_frame(12, 1'b0);
    s_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_count", 64'(mat_count), 64'd0);
    check("midrst_mat_in0", 64'(mat_in[W-1:0]), 64'd0);
    s_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    send_frame(NN, 1'b0);
    idle(3);
    check("midrst_count_after", 64'(mat_count), 64'd1);
    complete_one();

    // Randomized traffic
    rand_ctl = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 9) < 7) ? NN : $urandom_range(1, 32);
      send_frame(len, 1'b1);
    end
    idle(20);
    rand_ctl = 1'b0;
    inv_ready = 1'b1; inv_out_vld = 1'b0;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
